// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a show-ahead
// byte FIFO drained by a single-cycle rd_en strobe; everything runs on clk.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DEPTH_LOG2   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rxd,
   input  logic                  rd_en,
   output logic [7:0]            dout,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overrun,
   output logic                  frame_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [15:0]         HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0]         FULL_M1  = 16'(CLKS_PER_BIT - 1);
   localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
      return ~(^{d, p});
   endfunction
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd4
   } state_t;
`endif

   logic                  sync1_r;
   logic                  rxs_r;
   state_t                state_r;
   logic [15:0]           tmr_r;
   logic [2:0]            idx_r;
   logic [7:0]            shift_r;
   logic                  push_r;
   logic                  bad_r;
`ifdef UART_RX_PARITY_EN
   logic                  par_r;
`endif
   logic                  stop_ok_s;

   logic [7:0]            mem_r [0:DEPTH-1];
   logic [DEPTH_LOG2-1:0] wr_ptr_r;
   logic [DEPTH_LOG2-1:0] rd_ptr_r;
   logic [DEPTH_LOG2:0]   count_r;
   logic                  empty_r;
   logic                  full_r;
   logic                  overrun_r;
   logic                  frame_err_r;
   logic                  pop_ok_s;
   logic                  wr_ok_s;
   logic [DEPTH_LOG2:0]   count_nxt_s;

   // Two-flop synchroniser for the asynchronous line, idling high.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b1;
         rxs_r   <= 1'b1;
      end else begin
         sync1_r <= rxd;
         rxs_r   <= sync1_r;
      end
   end

   // Stop-bit acceptance, including the even-parity check when compiled in.
   always_comb begin
`ifdef UART_RX_PARITY_EN
      stop_ok_s = rxs_r & even_parity_ok(shift_r, par_r);
`else
      stop_ok_s = rxs_r;
`endif
   end

   // Deframing FSM: samples mid-bit and hands one push or error strobe to the FIFO stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         tmr_r   <= 16'd0;
         idx_r   <= 3'd0;
         shift_r <= 8'd0;
         push_r  <= 1'b0;
         bad_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_r   <= 1'b0;
`endif
      end else begin
         push_r <= 1'b0;
         bad_r  <= 1'b0;
         case (state_r)
            IDLE: begin
               tmr_r <= 16'd0;
               if (!rxs_r) begin
                  state_r <= START;
               end
            end
            START: begin
               if (tmr_r == HALF_M1) begin
                  tmr_r   <= 16'd0;
                  idx_r   <= 3'd0;
                  state_r <= rxs_r ? IDLE : DATA;
               end else begin
                  tmr_r <= tmr_r + 16'd1;
               end
            end
            DATA: begin
               if (tmr_r == FULL_M1) begin
                  tmr_r          <= 16'd0;
                  shift_r[idx_r] <= rxs_r;
                  idx_r          <= idx_r + 3'd1;
                  if (idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_r <= PARITY;
`else
                     state_r <= STOP;
`endif
                  end
               end else begin
                  tmr_r <= tmr_r + 16'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tmr_r == FULL_M1) begin
                  tmr_r   <= 16'd0;
                  par_r   <= rxs_r;
                  state_r <= STOP;
               end else begin
                  tmr_r <= tmr_r + 16'd1;
               end
            end
`endif
            STOP: begin
               if (tmr_r == FULL_M1) begin
                  tmr_r   <= 16'd0;
                  state_r <= IDLE;
                  if (stop_ok_s) begin
                     push_r <= 1'b1;
                  end else begin
                     bad_r <= 1'b1;
                  end
               end else begin
                  tmr_r <= tmr_r + 16'd1;
               end
            end
            default: begin
               state_r <= IDLE;
               tmr_r   <= 16'd0;
            end
         endcase
      end
   end

   // FIFO handshake: a pop on a full FIFO frees the slot the same-cycle push lands in.
   always_comb begin
      pop_ok_s    = rd_en & ~empty_r;
      wr_ok_s     = push_r & (~full_r | pop_ok_s);
      count_nxt_s = count_r;
      if (wr_ok_s && !pop_ok_s) begin
         count_nxt_s = count_r + CNT_ONE;
      end else if (!wr_ok_s && pop_ok_s) begin
         count_nxt_s = count_r - CNT_ONE;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // FIFO storage; contents are not reset, only the pointers are.
   always_ff @(posedge clk) begin
      if (wr_ok_s) begin
         mem_r[wr_ptr_r] <= shift_r;
      end
   end

   // FIFO pointers, occupancy flags and the one-cycle status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r    <= {DEPTH_LOG2{1'b0}};
         rd_ptr_r    <= {DEPTH_LOG2{1'b0}};
         count_r     <= {(DEPTH_LOG2 + 1){1'b0}};
         empty_r     <= 1'b1;
         full_r      <= 1'b0;
         overrun_r   <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         if (wr_ok_s) begin
            wr_ptr_r <= wr_ptr_r + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
         end
         count_r     <= count_nxt_s;
         empty_r     <= (count_nxt_s == {(DEPTH_LOG2 + 1){1'b0}});
         full_r      <= (count_nxt_s == CNT_FULL);
         overrun_r   <= push_r & full_r & ~pop_ok_s;
         frame_err_r <= bad_r;
      end
   end

   assign dout      = mem_r[rd_ptr_r];
   assign empty     = empty_r;
   assign full      = full_r;
   assign count     = count_r;
   assign overrun   = overrun_r;
   assign frame_err = frame_err_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: frame table plus hand-written corner sequences,
// with a byte scoreboard compared as the FIFO is drained.
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DL2   = 4;
   localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int LAT = 2 + CPB / 2 + (NBITS - 1) * CPB + 1;

   logic         clk;
   logic         rst;
   logic         rxd;
   logic         rd_en;
   logic [7:0]   dout;
   logic         empty;
   logic         full;
   logic [DL2:0] count;
   logic         overrun;
   logic         frame_err;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       bad_par;
      logic       exp_push;
   } vec_t;

   vec_t       vecs [6];
   logic [7:0] sb [$];
   int         n_pass;
   int         n_total;
   int         ferr_cnt;
   int         ovr_cnt;
   int         f0;
   int         o0;
   int         lat;
   int         cyc;

   uart_rx_fifo #(
      .CLKS_PER_BIT (CPB),
      .DEPTH_LOG2   (DL2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .rd_en     (rd_en),
      .dout      (dout),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters, sampled on the inactive edge.
   initial begin
      ferr_cnt = 0;
      ovr_cnt  = 0;
   end
   always @(negedge clk) begin
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (overrun)   ovr_cnt  = ovr_cnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total = n_total + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic send_bit(input logic b);
      rxd = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^d) ^ bad_par);
`else
      if (bad_par) rxd = 1'b1;
`endif
      send_bit(stop);
      rxd = 1'b1;
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic drain(input string name);
      logic [7:0] e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check({name, " not empty"}, 32'(empty), 32'd0);
         check({name, " dout"}, 32'(dout), 32'(e));
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
      end
      check({name, " drained"}, 32'(empty), 32'd1);
   endtask

   initial begin
      vecs[0] = '{data: 8'h3C, stop: 1'b1, bad_par: 1'b0, exp_push: 1'b1};
      vecs[1] = '{data: 8'h00, stop: 1'b1, bad_par: 1'b0, exp_push: 1'b1};
      vecs[2] = '{data: 8'hFF, stop: 1'b1, bad_par: 1'b0, exp_push: 1'b1};
      vecs[3] = '{data: 8'h81, stop: 1'b0, bad_par: 1'b0, exp_push: 1'b0};
      vecs[4] = '{data: 8'h5A, stop: 1'b1, bad_par: 1'b0, exp_push: 1'b1};
      vecs[5] = '{data: 8'h7E, stop: 1'b0, bad_par: 1'b0, exp_push: 1'b0};
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b1;
      rxd     = 1'b1;
      rd_en   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("reset empty", 32'(empty), 32'd1);
      check("reset full", 32'(full), 32'd0);
      check("reset count", 32'(count), 32'd0);
      check("reset overrun", 32'(overrun), 32'd0);
      check("reset frame_err", 32'(frame_err), 32'd0);
      idle(4);

      // Single byte with latency measurement
      lat = -1;
      fork
         send_frame(8'hA5, 1'b1, 1'b0);
         begin
            cyc = 0;
            while (cyc < 400 && lat < 0) begin
               @(posedge clk);
               cyc = cyc + 1;
               #1;
               if (!empty) lat = cyc - 1;
            end
         end
      join
      sb.push_back(8'hA5);
      n_total = n_total + 1;
      if (lat >= LAT - 1 && lat <= LAT + 1) n_pass = n_pass + 1;
      else $display("FAIL latency: got %0d cycles, expected %0d +-1", lat, LAT);
      check("single count", 32'(count), 32'd1);
      drain("single");
      check("single count after pop", 32'(count), 32'd0);

      // Frame table
      foreach (vecs[i]) begin
         f0 = ferr_cnt;
         send_frame(vecs[i].data, vecs[i].stop, vecs[i].bad_par);
         idle(2 * CPB);
         if (vecs[i].exp_push) sb.push_back(vecs[i].data);
         check($sformatf("vec%0d frame_err", i), 32'(ferr_cnt - f0), 32'(!vecs[i].exp_push));
         check($sformatf("vec%0d count", i), 32'(count), 32'(sb.size()));
      end
      drain("table");

      // Short glitch
      f0 = ferr_cnt;
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      idle(3 * CPB);
      check("glitch frame_err", 32'(ferr_cnt - f0), 32'd0);
      check("glitch count", 32'(count), 32'd0);

      // Break: line held low for 30 bit periods
      f0 = ferr_cnt;
      rxd = 1'b0;
      repeat (30 * CPB) @(negedge clk);
      check("break frame_err>=2", 32'(ferr_cnt - f0 >= 2), 32'd1);
      check("break count", 32'(count), 32'd0);
      idle(2 * NBITS * CPB);
      do_reset();
      idle(CPB);

      // Fill and overrun, back-to-back frames
      o0 = ovr_cnt;
      for (int b = 0; b < DEPTH; b++) begin
         send_frame(8'(b), 1'b1, 1'b0);
         sb.push_back(8'(b));
      end
      check("fill full", 32'(full), 32'd1);
      check("fill count", 32'(count), 32'd16);
      send_frame(8'h10, 1'b1, 1'b0);
      idle(2 * CPB);
      check("overrun pulses", 32'(ovr_cnt - o0), 32'd1);
      check("overrun count", 32'(count), 32'd16);
      drain("fill");

      // Simultaneous push and pop while full
      for (int b = 0; b < DEPTH; b++) begin
         send_frame(8'h40 + 8'(b), 1'b1, 1'b0);
         sb.push_back(8'h40 + 8'(b));
      end
      o0 = ovr_cnt;
      fork
         send_frame(8'h5A, 1'b1, 1'b0);
         begin
            repeat (LAT) @(negedge clk);
            check("simul head dout", 32'(dout), 32'(sb[0]));
            void'(sb.pop_front());
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
         end
      join
      sb.push_back(8'h5A);
      idle(CPB);
      check("simul count", 32'(count), 32'd16);
      check("simul full", 32'(full), 32'd1);
      check("simul overrun", 32'(ovr_cnt - o0), 32'd0);
      drain("simul");

      // Reset during DATA with bytes queued
      send_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, 1'b0);
      send_frame(8'h33, 1'b1, 1'b0);
      idle(2 * CPB);
      check("pre-reset count", 32'(count), 32'd3);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      rxd = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      do_reset();
      check("midreset count", 32'(count), 32'd0);
      check("midreset empty", 32'(empty), 32'd1);
      idle(2 * CPB);
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b1, 1'b0);
      idle(2 * CPB);
      sb.push_back(8'h3C);
      check("post-reset frame_err", 32'(ferr_cnt - f0), 32'd0);
      check("post-reset count", 32'(count), 32'd1);
      drain("post-reset");

`ifdef UART_RX_PARITY_EN
      f0 = ferr_cnt;
      send_frame(8'h07, 1'b1, 1'b0);
      idle(2 * CPB);
      sb.push_back(8'h07);
      check("parity good count", 32'(count), 32'd1);
      check("parity good frame_err", 32'(ferr_cnt - f0), 32'd0);
      send_frame(8'h07, 1'b1, 1'b1);
      idle(2 * CPB);
      check("parity bad frame_err", 32'(ferr_cnt - f0), 32'd1);
      check("parity bad count", 32'(count), 32'd1);
      drain("parity");
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end that feeds the core's `rxd`-side input path. It synchronises the raw UART line, deframes 8N1 bytes (8E1 with the parity option), and buffers them in a small show-ahead FIFO. The core drains the FIFO with a single-cycle pop strobe. The block runs entirely in the core clock domain (`clk_out2`), upstream of the core's UART input logic.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: core clock cycles per UART bit (100 MHz / 115200). Legal range 8..65535.
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries.

Ports:
- `clk`, input, 1: core clock. The block is clocked on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rxd`, input, 1: raw asynchronous UART line, idle high.
- `rd_en`, input, 1: pop strobe. It is ignored when `empty`=1.
- `dout`, output, 8: head-of-FIFO byte. Valid whenever `empty`=0.
- `empty`, output, 1: FIFO holds 0 entries.
- `full`, output, 1: FIFO holds 2^DEPTH_LOG2 entries.
- `count`, output, DEPTH_LOG2+1: current occupancy.
- `overrun`, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.
- `frame_err`, output, 1: one-cycle pulse when the stop bit samples 0, or on parity mismatch when the parity option is compiled in.

## Operation
- **Synchroniser.** `rxd` passes through a 2-flop synchroniser; both flops reset to 1. The FSM sees only the synchronised value `rxs`.
- **FSM states.** IDLE, START, DATA, PARITY (compiled only with the option), STOP. A 16-bit bit-timer `tmr` and a 3-bit bit-index `idx` track position.
  - **IDLE:** on `rxs`=0, go to START with `tmr`=0.
  - **START:** when `tmr`=CLKS_PER_BIT/2−1, re-sample.
    - If `rxs`=0, go to DATA with `tmr`=0 and `idx`=0.
    - Else it was a glitch: return to IDLE and push nothing.
  - **DATA:** when `tmr`=CLKS_PER_BIT−1, shift `rxs` into bit `idx` (LSB first). Go to the next state after `idx`=7.
  - **PARITY:** one bit period, then sample into `par`.
  - **STOP:** when `tmr`=CLKS_PER_BIT−1, sample and go to IDLE.
    - Sample 1 and parity OK: push the byte.
    - Otherwise: pulse `frame_err` and discard the byte.
- **Line held low (break).** The FSM re-enters START only when it is in IDLE and `rxs`=0. A line held low produces repeated frame errors, one per frame period. No bytes are pushed.
- **FIFO.** Circular buffer with DEPTH_LOG2-bit read/write pointers that wrap modulo depth. `count` is tracked explicitly.
  - `dout` is mem[rd_ptr], driven combinationally from registered storage (show-ahead).
  - Push while `full`=0: write at wr_ptr and increment.
  - Push while `full`=1 and no pop in the same cycle: drop the byte and pulse `overrun`.
  - Push and pop in the same cycle while `full`=1: both succeed, `count` is unchanged, no `overrun`.
  - Push and pop in the same cycle while `empty`=1: push only (the pop is ignored), and `count` becomes 1.
- **Reset.** `rst` at any point, including mid-frame, has the following effect:
  - FSM returns to IDLE.
  - Pointers and `count` become 0, and the partially received byte is lost.
  - Outputs take these values: `empty`=1, `full`=0, `count`=0, `overrun`=0, `frame_err`=0, `dout`=mem[0] (contents undefined, ignore).
  - A frame already in progress on the line after reset release is resynchronised at the next idle-to-low transition seen in IDLE.

## Timing
- **Latency.** Measured from the first rising `clk` edge at which `rxd`=0 is sampled to `empty` falling (FIFO previously empty): 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles (+CLKS_PER_BIT with parity). The bench allows ±1 cycle.
- **Pop.** `rd_en` high with `empty`=0 at edge N: `dout` shows the next entry and `count` decrements at edge N+1.
- **Error and overrun pulses.** `frame_err` and `overrun` are registered and asserted for exactly one cycle, coincident with the cycle in which the push would have updated `count`.
- **Back-to-back frames.** Frames with a 1-bit stop and no idle gap are received without loss. The FSM is in IDLE with CLKS_PER_BIT/2 cycles of margin before the next start edge.

## Configuration
- `UART_RX_PARITY_EN`:
  - **Defined:** frame is start + 8 data + even parity + stop. PARITY state is present. A byte with odd parity over data+parity is discarded with a `frame_err` pulse.
  - **Undefined:** 8N1. PARITY state and `par` logic are absent.

## Test plan
- **Single byte.** CLKS_PER_BIT=16; send 0xA5 8N1 → `empty` falls within 2+8+144+1 ±1 cycles; `dout`=0xA5, `count`=1; `rd_en` pulse → `empty`=1, `count`=0.
- **Fill and overrun.** Send 17 back-to-back bytes 0x00..0x10 with no pops, DEPTH_LOG2=4 → `full`=1 after 16 bytes; `overrun` pulses once on byte 0x10; pops return 0x00..0x0F in order.
- **Glitch and break.** A 3-cycle low glitch on `rxd` → no push, no `frame_err`. Hold `rxd` low for 30 bit periods → ≥2 `frame_err` pulses and `count` stays 0.
- **Simultaneous push/pop when full.** FIFO full; assert `rd_en` in the push cycle of byte 0x5A → `count` stays 16, no `overrun`, and 0x5A is read out last.
- **Reset mid-frame.** Assert `rst` for 1 cycle during DATA of a byte with 3 bytes queued → `count`=0 and `empty`=1 next cycle. The following clean frame 0x3C is received correctly.
- **Parity (UART_RX_PARITY_EN defined).** Send 0x07 with parity bit 1 → pushed. Send 0x07 with parity bit 0 → `frame_err` pulse, no push.
